pwm_fade_ctrl: RTL and testbench

- Duty-cycle sequencer that drives the 8-bit duty input of the board's PWM generator in place of raw switch values.
- Modes: manual pass-through, triangle "breathe" ramp, square blink, and forced off.
- Keeps its own PWM-period counter so duty changes land only on period boundaries, giving glitch-free brightness steps.
- Sits between the board switches/top level and the PWM instance.

---
 rtl/pwm_fade_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer for the PWM generator: manual, breathe, blink and off modes.
// All updates land on PWM period boundaries. Optional gamma output: define PWM_FADE_GAMMA_EN.
module pwm_fade_ctrl #(
  parameter int DUTY_W           = 8,
  parameter int PERIODS_PER_STEP = 763
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [1:0]        mode,
  input  logic [DUTY_W-1:0] sw_duty,
  input  logic [DUTY_W-1:0] duty_lo,
  input  logic [DUTY_W-1:0] duty_hi,
  input  logic [3:0]        step,
  output logic [DUTY_W-1:0] duty,
  output logic              period_start,
  output logic              at_limit
);

  localparam int SCW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [SCW-1:0]    SC_LAST  = SCW'(PERIODS_PER_STEP - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST = '1;
  localparam logic [DUTY_W:0]   STEP_ONE = (DUTY_W+1)'(1);

  typedef enum logic [2:0] {
    S_OFF,
    S_MANUAL,
    S_UP,
    S_DOWN,
    S_BLINK_HI,
    S_BLINK_LO
  } state_t;

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [SCW-1:0]    scnt_q, scnt_d;
  logic [DUTY_W-1:0] lin_q, lin_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              period_start_q, period_start_d;
  logic              at_limit_q, at_limit_d;

  logic              pend;
  logic              tick;
  logic [DUTY_W-1:0] lo;
  logic [DUTY_W-1:0] hi;
  logic [DUTY_W:0]   step_ext;
  logic [DUTY_W-1:0] clamped;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   dn_diff;
  logic [DUTY_W-1:0] up_val;
  logic [DUTY_W-1:0] dn_val;

`ifdef PWM_FADE_GAMMA_EN
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
  logic [2*DUTY_W-1:0] lin_sq;
`endif

  // Ramp datapath: limits, clamped current value and saturating up/down steps.
  always_comb begin
    pend     = (cnt_q == CNT_LAST);
    tick     = pend && (scnt_q == SC_LAST);
    lo       = duty_lo;
    hi       = (duty_lo >= duty_hi) ? duty_lo : duty_hi;
    step_ext = (step == 4'd0) ? STEP_ONE : {{(DUTY_W-3){1'b0}}, step};

    if (lin_q < lo) begin
      clamped = lo;
    end else if (lin_q > hi) begin
      clamped = hi;
    end else begin
      clamped = lin_q;
    end

    up_sum  = {1'b0, clamped} + step_ext;
    dn_diff = {1'b0, clamped} - step_ext;
    up_val  = (up_sum >= {1'b0, hi}) ? hi : up_sum[DUTY_W-1:0];
    // A set MSB on the difference means the step went below zero.
    dn_val  = (dn_diff[DUTY_W] || (dn_diff[DUTY_W-1:0] <= lo)) ? lo : dn_diff[DUTY_W-1:0];
  end

  always_comb begin
    cnt_d          = cnt_q + 1'b1;
    scnt_d         = scnt_q;
    state_d        = state_q;
    lin_d          = lin_q;
    duty_d         = duty_q;
    at_limit_d     = at_limit_q;
    period_start_d = pend;
`ifdef PWM_FADE_GAMMA_EN
    lin_sq         = '0;
`endif

    if (pend) begin
      scnt_d = (scnt_q == SC_LAST) ? '0 : scnt_q + 1'b1;

      case (mode)
        2'b11: begin
          state_d = S_OFF;
          lin_d   = '0;
        end
        2'b00: begin
          state_d = S_MANUAL;
          lin_d   = sw_duty;
        end
        2'b01: begin
          if (state_q == S_UP || state_q == S_DOWN) begin
            lin_d = clamped;
            if (tick) begin
              if (state_q == S_UP) begin
                lin_d = up_val;
                if (up_val == hi) state_d = S_DOWN;
              end else begin
                lin_d = dn_val;
                if (dn_val == lo) state_d = S_UP;
              end
            end
          end else begin
            state_d = S_UP;
            lin_d   = lo;
            scnt_d  = '0;
          end
        end
        default: begin
          if (state_q == S_BLINK_HI || state_q == S_BLINK_LO) begin
            if (tick) begin
              if (state_q == S_BLINK_HI) begin
                state_d = S_BLINK_LO;
                lin_d   = lo;
              end else begin
                state_d = S_BLINK_HI;
                lin_d   = hi;
              end
            end
          end else begin
            state_d = S_BLINK_HI;
            lin_d   = hi;
            scnt_d  = '0;
          end
        end
      endcase

      at_limit_d = (state_d inside {S_UP, S_DOWN, S_BLINK_HI, S_BLINK_LO}) &&
                   ((lin_d == lo) || (lin_d == hi));

      duty_d = lin_d;
`ifdef PWM_FADE_GAMMA_EN
      // Perceptual curve on ramps only; full scale is pinned so the top is reachable.
      lin_sq = {{DUTY_W{1'b0}}, lin_d} * {{DUTY_W{1'b0}}, lin_d};
      if (state_d == S_UP || state_d == S_DOWN) begin
        if (hi == DUTY_MAX && lin_d == hi) begin
          duty_d = hi;
        end else begin
          duty_d = lin_sq[2*DUTY_W-1:DUTY_W];
        end
      end
`endif
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q        <= S_OFF;
      cnt_q          <= '0;
      scnt_q         <= '0;
      lin_q          <= '0;
      duty_q         <= '0;
      period_start_q <= 1'b0;
      at_limit_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      scnt_q         <= scnt_d;
      lin_q          <= lin_d;
      duty_q         <= duty_d;
      period_start_q <= period_start_d;
      at_limit_q     <= at_limit_d;
    end
  end

  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign at_limit     = at_limit_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: expected duty/at_limit per PWM period are queued
// by the stimulus and popped by a monitor on every period_start pulse.
module tb_pwm_fade_ctrl;

  localparam int DUTY_W = 8;
  localparam int PPS    = 2;

  logic              CLOCK_50 = 1'b0;
  logic              RESET    = 1'b1;
  logic [1:0]        mode;
  logic [DUTY_W-1:0] sw_duty;
  logic [DUTY_W-1:0] duty_lo;
  logic [DUTY_W-1:0] duty_hi;
  logic [3:0]        step;
  logic [DUTY_W-1:0] duty;
  logic              period_start;
  logic              at_limit;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic              at_limit;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   checks    = 0;
  int   errors    = 0;
  int   periodIdx = 0;
  int   cyc;

  logic [7:0] rampVals [10] = '{8'h10, 8'h18, 8'h20, 8'h28, 8'h30,
                                8'h38, 8'h40, 8'h38, 8'h30, 8'h28};

  pwm_fade_ctrl #(.DUTY_W(DUTY_W), .PERIODS_PER_STEP(PPS)) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET        (RESET),
    .mode         (mode),
    .sw_duty      (sw_duty),
    .duty_lo      (duty_lo),
    .duty_hi      (duty_hi),
    .step         (step),
    .duty         (duty),
    .period_start (period_start),
    .at_limit     (at_limit)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] sw,
                               input logic [7:0] lo, input logic [7:0] hi,
                               input logic [3:0] st);
    mode    = m;
    sw_duty = sw;
    duty_lo = lo;
    duty_hi = hi;
    step    = st;
  endtask

  task automatic pushHold(input logic [7:0] d, input logic al, input int n);
    exp_t e;
    e.duty     = d;
    e.at_limit = al;
    for (int i = 0; i < n; i++) expQ.push_back(e);
  endtask

  task automatic waitPeriods(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      @(negedge CLOCK_50);
      while (period_start !== 1'b1 && guard < 300) begin
        @(negedge CLOCK_50);
        guard++;
      end
      if (period_start !== 1'b1) begin
        checks++;
        errors++;
        $display("[TB] FAIL period_timeout: got no period_start, expected one within 300 cycles");
      end
    end
  endtask

  task automatic cyclesToPeriod(output int c);
    c = 0;
    do begin
      @(negedge CLOCK_50);
      c++;
    end while (period_start !== 1'b1 && c < 600);
  endtask

  // Monitor: every period_start carries the duty for that period.
  always @(negedge CLOCK_50) begin
    if (period_start === 1'b1) begin
      periodIdx++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_period: got period_start #%0d with duty 0x%0h, expected none",
                 periodIdx, duty);
      end else begin
        monExp = expQ.pop_front();
        checkOutput($sformatf("period%0d_duty", periodIdx), 32'(duty), 32'(monExp.duty));
        checkOutput($sformatf("period%0d_at_limit", periodIdx), 32'(at_limit),
                    32'(monExp.at_limit));
      end
    end
  end

  initial begin
    // Reset and manual pass-through.
    applyStimulus(2'b00, 8'h80, 8'h00, 8'h00, 4'd0);
    RESET = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("reset_duty", 32'(duty), 32'h0);
    checkOutput("reset_period_start", 32'(period_start), 32'h0);
    checkOutput("reset_at_limit", 32'(at_limit), 32'h0);
    pushHold(8'h80, 1'b0, 2);
    RESET = 1'b0;
    repeat (255) @(negedge CLOCK_50);
    checkOutput("duty_before_first_pend", 32'(duty), 32'h0);
    checkOutput("no_early_period_start", 32'(period_start), 32'h0);
    @(negedge CLOCK_50);
    checkOutput("first_period_start_at_256", 32'(period_start), 32'h1);
    cyclesToPeriod(cyc);
    checkOutput("period_spacing", 32'(cyc), 32'd256);

    // Breathe ramp up 0x10..0x40 and back down to 0x28.
    applyStimulus(2'b01, 8'h80, 8'h10, 8'h40, 4'd8);
    for (int i = 0; i < 10; i++) begin
      pushHold(rampVals[i], (rampVals[i] == 8'h10) || (rampVals[i] == 8'h40), (i == 9) ? 1 : 2);
    end
    waitPeriods(19);

    // Reset in the middle of a falling ramp.
    repeat (100) @(negedge CLOCK_50);
    RESET = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("midramp_reset_duty", 32'(duty), 32'h0);
    checkOutput("midramp_reset_at_limit", 32'(at_limit), 32'h0);
    checkOutput("midramp_reset_period_start", 32'(period_start), 32'h0);

    // Upward saturation: 0xF1 + 0xF must clamp to 0xFF rather than wrap.
    applyStimulus(2'b01, 8'h00, 8'hF1, 8'hFF, 4'hF);
    pushHold(8'hF1, 1'b1, 2);
    pushHold(8'hFF, 1'b1, 2);
    pushHold(8'hF1, 1'b1, 2);
    RESET = 1'b0;
    cyclesToPeriod(cyc);
    checkOutput("period_after_reset", 32'(cyc), 32'd256);
    waitPeriods(5);

    // Limits moved to [0,5]: clamp to 5, then 5 - 0xF must floor at 0.
    applyStimulus(2'b01, 8'h00, 8'h00, 8'h05, 4'hF);
    pushHold(8'h05, 1'b1, 2);
    pushHold(8'h00, 1'b1, 2);
    pushHold(8'h05, 1'b1, 1);
    waitPeriods(5);

    // step=0 behaves as 1, hi lowered to 4 while falling.
    applyStimulus(2'b01, 8'h00, 8'h00, 8'h04, 4'd0);
    pushHold(8'h04, 1'b1, 1);
    pushHold(8'h03, 1'b0, 2);
    pushHold(8'h02, 1'b0, 2);
    pushHold(8'h01, 1'b0, 2);
    pushHold(8'h00, 1'b1, 2);
    pushHold(8'h01, 1'b0, 1);
    waitPeriods(10);

    // Degenerate limits: lo above hi holds at lo.
    applyStimulus(2'b01, 8'h00, 8'h50, 8'h30, 4'd8);
    pushHold(8'h50, 1'b1, 4);
    waitPeriods(4);

    // Blink between 0xC0 and 0x00.
    applyStimulus(2'b10, 8'h00, 8'h00, 8'hC0, 4'd8);
    pushHold(8'hC0, 1'b1, 2);
    pushHold(8'h00, 1'b1, 2);
    pushHold(8'hC0, 1'b1, 2);
    waitPeriods(6);

    // Mid-period switch to OFF: duty holds until the boundary.
    repeat (100) @(negedge CLOCK_50);
    applyStimulus(2'b11, 8'h00, 8'h00, 8'hC0, 4'd8);
    pushHold(8'h00, 1'b0, 1);
    repeat (150) @(negedge CLOCK_50);
    checkOutput("off_hold_before_pend", 32'(duty), 32'hC0);
    waitPeriods(1);

    repeat (10) @(negedge CLOCK_50);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
